// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM stage of the 5-stage MIPS core plus the MEM/WB pipeline register.
// Performs byte-enabled data-memory writes, lane-extracted loads with sign/zero
// extension, flags illegal enable patterns and out-of-range addresses, and registers
// the write-back payload with stall/bubble control from the hazard unit.
module mem_wb_stage #(
  parameter int DM_WORDS = 4096,
  parameter int AW       = 12
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        bubble,
  input  logic [31:0] ex_mem_instr,
  input  logic [31:0] ex_mem_pc,
  input  logic [31:0] alu_out,
  input  logic [31:0] store_data,
  input  logic [3:0]  mem_write,
  input  logic [3:0]  mem_read,
  input  logic        load_signed,
  input  logic [4:0]  ex_mem_waddr,
  input  logic        ex_mem_regwrite,
  output logic [31:0] mem_wb_instr,
  output logic [31:0] mem_wb_pc,
  output logic [31:0] mem_wb_result,
  output logic [4:0]  mem_wb_waddr,
  output logic        mem_wb_regwrite,
  output logic        mem_err
);

  // Data memory. Contents are not reset directly; a per-word valid bit is cleared
  // asynchronously instead, and an invalid word reads as zero. This gives the
  // "memory cleared on reset" behaviour without touching every storage word.
  logic [31:0]         dm_mem [DM_WORDS];
  logic [DM_WORDS-1:0] dm_valid_reg;

  logic [AW-1:0] word_idx;
  logic          in_range;
  logic [31:0]   old_word;
  logic [31:0]   wdata_rep;
  logic [31:0]   merged_word;
  logic          write_ok;
  logic [31:0]   load_data;
  logic [31:0]   result_next;
  logic          err_next;

  assign word_idx = alu_out[AW+1:2];
  assign in_range = (alu_out[31:AW+2] == '0);

  // Only byte, aligned-halfword and full-word lane patterns are legal.
  function automatic logic pattern_ok(input logic [3:0] p);
    case (p)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: return 1'b1;
      default:                   return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ext8(input logic [7:0] b, input logic s);
    return {{24{s & b[7]}}, b};
  endfunction

  function automatic logic [31:0] ext16(input logic [15:0] h, input logic s);
    return {{16{s & h[15]}}, h};
  endfunction

  // Current (pre-write) content of the addressed word; out-of-range reads give 0.
  always_comb begin
    old_word = '0;
    if (in_range && dm_valid_reg[word_idx]) begin
      old_word = dm_mem[word_idx];
    end
  end

  // Replicate the low store bits across the lanes so each enabled lane just picks its byte.
  always_comb begin
    wdata_rep = store_data;
    case (mem_write)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: wdata_rep = {4{store_data[7:0]}};
      4'b0011, 4'b1100:                   wdata_rep = {2{store_data[15:0]}};
      default:                            wdata_rep = store_data;
    endcase
  end

  // Per-lane merge: enabled lanes take new data, the rest keep the old word.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign merged_word[8*gi +: 8] = mem_write[gi] ? wdata_rep[8*gi +: 8]
                                                    : old_word[8*gi +: 8];
    end
  endgenerate

  assign write_ok = pattern_ok(mem_write) && !stall && in_range;

  // Whole-word read-modify-write into the data memory array.
  always_ff @(posedge clk) begin
    if (write_ok) begin
      dm_mem[word_idx] <= merged_word;
    end
  end

  // Valid bits: cleared by reset, set by any accepted write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dm_valid_reg <= '0;
    end else if (write_ok) begin
      dm_valid_reg[word_idx] <= 1'b1;
    end
  end

  // Lane extraction and extension of the load value.
  always_comb begin
    load_data = '0;
    if (in_range) begin
      case (mem_read)
        4'b0001: load_data = ext8(old_word[7:0],   load_signed);
        4'b0010: load_data = ext8(old_word[15:8],  load_signed);
        4'b0100: load_data = ext8(old_word[23:16], load_signed);
        4'b1000: load_data = ext8(old_word[31:24], load_signed);
        4'b0011: load_data = ext16(old_word[15:0],  load_signed);
        4'b1100: load_data = ext16(old_word[31:16], load_signed);
        4'b1111: load_data = old_word;
        default: load_data = '0;
      endcase
    end
  end

  // Write-back value and access-error flag for this cycle.
  always_comb begin
    result_next = (mem_read != 4'b0000) ? load_data : alu_out;
    err_next    = 1'b0;
    if ((mem_write != 4'b0000) && !pattern_ok(mem_write)) err_next = 1'b1;
    if ((mem_read  != 4'b0000) && !pattern_ok(mem_read))  err_next = 1'b1;
    if (((mem_write | mem_read) != 4'b0000) && !in_range) err_next = 1'b1;
  end

  // MEM/WB register: reset > stall (hold) > bubble (NOP) > capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_wb_instr    <= '0;
      mem_wb_pc       <= '0;
      mem_wb_result   <= '0;
      mem_wb_waddr    <= '0;
      mem_wb_regwrite <= 1'b0;
      mem_err         <= 1'b0;
    end else if (stall) begin
      mem_wb_instr    <= mem_wb_instr;
      mem_wb_pc       <= mem_wb_pc;
      mem_wb_result   <= mem_wb_result;
      mem_wb_waddr    <= mem_wb_waddr;
      mem_wb_regwrite <= mem_wb_regwrite;
      mem_err         <= mem_err;
    end else if (bubble) begin
      mem_wb_instr    <= '0;
      mem_wb_pc       <= '0;
      mem_wb_result   <= '0;
      mem_wb_waddr    <= '0;
      mem_wb_regwrite <= 1'b0;
      mem_err         <= 1'b0;
    end else begin
      mem_wb_instr    <= ex_mem_instr;
      mem_wb_pc       <= ex_mem_pc;
      mem_wb_result   <= result_next;
      // A non-writing instruction reports $0 so hazard checks never match it.
      mem_wb_waddr    <= ex_mem_regwrite ? ex_mem_waddr : 5'd0;
      mem_wb_regwrite <= ex_mem_regwrite;
      mem_err         <= err_next;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Testbench for mem_wb_stage: byte-addressed behavioural model, per-cycle compare
// process, directed literal checks and randomized traffic.
module tb_mem_wb_stage;
  localparam int DW    = 4096;
  localparam int BYTES = DW * 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall, bubble;
  logic [31:0] ex_mem_instr, ex_mem_pc, alu_out, store_data;
  logic [3:0]  mem_write, mem_read;
  logic        load_signed;
  logic [4:0]  ex_mem_waddr;
  logic        ex_mem_regwrite;
  logic [31:0] mem_wb_instr, mem_wb_pc, mem_wb_result;
  logic [4:0]  mem_wb_waddr;
  logic        mem_wb_regwrite, mem_err;

  int checks   = 0;
  int failures = 0;
  bit check_en = 1'b0;

  // Expected registered outputs and byte-addressed memory model.
  logic [31:0] e_instr, e_pc, e_result;
  logic [4:0]  e_waddr;
  logic        e_rw, e_err;
  logic [7:0]  mb [BYTES];

  mem_wb_stage #(.DM_WORDS(DW), .AW(12)) dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .bubble(bubble),
    .ex_mem_instr(ex_mem_instr), .ex_mem_pc(ex_mem_pc), .alu_out(alu_out),
    .store_data(store_data), .mem_write(mem_write), .mem_read(mem_read),
    .load_signed(load_signed), .ex_mem_waddr(ex_mem_waddr),
    .ex_mem_regwrite(ex_mem_regwrite), .mem_wb_instr(mem_wb_instr),
    .mem_wb_pc(mem_wb_pc), .mem_wb_result(mem_wb_result),
    .mem_wb_waddr(mem_wb_waddr), .mem_wb_regwrite(mem_wb_regwrite),
    .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Lane pattern -> first byte lane and access size in bytes (0 = illegal).
  function automatic void decode(input logic [3:0] p, output int lane, output int n);
    lane = 0; n = 0;
    case (p)
      4'b0001: begin lane = 0; n = 1; end
      4'b0010: begin lane = 1; n = 1; end
      4'b0100: begin lane = 2; n = 1; end
      4'b1000: begin lane = 3; n = 1; end
      4'b0011: begin lane = 0; n = 2; end
      4'b1100: begin lane = 2; n = 2; end
      4'b1111: begin lane = 0; n = 4; end
      default: begin lane = 0; n = 0; end
    endcase
  endfunction

  task automatic model_clear();
    foreach (mb[i]) mb[i] = 8'h00;
    e_instr = '0; e_pc = '0; e_result = '0; e_waddr = '0; e_rw = 1'b0; e_err = 1'b0;
  endtask

  // Apply one transaction at a falling edge, predict the register contents after the
  // next rising edge, then advance to the following falling edge.
  task automatic drive(input logic [31:0] instr, input logic [31:0] alu, input logic [31:0] sd,
                       input logic [3:0] mw, input logic [3:0] mr, input logic ls,
                       input logic st, input logic bb);
    int wl, wn, rl, rn;
    bit inr;
    logic [31:0] ld, pc;
    logic [4:0] wa;
    logic rw;
    int unsigned base;
    pc = $urandom; wa = 5'($urandom); rw = 1'($urandom);
    ex_mem_instr = instr; ex_mem_pc = pc; alu_out = alu; store_data = sd;
    mem_write = mw; mem_read = mr; load_signed = ls; stall = st; bubble = bb;
    ex_mem_waddr = wa; ex_mem_regwrite = rw;
    decode(mw, wl, wn);
    decode(mr, rl, rn);
    inr  = (alu < 32'(BYTES));
    base = alu & 32'hFFFF_FFFC;
    ld = '0;
    if (mr != 0 && rn != 0 && inr) begin
      for (int k = 0; k < rn; k++) ld = ld | (32'(mb[base + rl + k]) << (8 * k));
      if (ls && rn < 4 && ld[8*rn-1]) ld = ld | (32'hFFFF_FFFF << (8 * rn));
    end
    if (!st) begin
      if (bb) begin
        e_instr = '0; e_pc = '0; e_result = '0; e_waddr = '0; e_rw = 1'b0; e_err = 1'b0;
      end else begin
        e_instr  = instr;
        e_pc     = pc;
        e_result = (mr != 0) ? ld : alu;
        e_rw     = rw;
        e_waddr  = rw ? wa : 5'd0;
        e_err    = (mw != 0 && wn == 0) || (mr != 0 && rn == 0) || ((mw | mr) != 0 && !inr);
      end
      if (wn != 0 && inr) begin
        for (int k = 0; k < wn; k++) mb[base + wl + k] = 8'(sd >> (8 * k));
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Per-cycle comparison against the model, just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (check_en) begin
      chk("instr",    mem_wb_instr,           e_instr);
      chk("pc",       mem_wb_pc,              e_pc);
      chk("result",   mem_wb_result,          e_result);
      chk("waddr",    32'(mem_wb_waddr),      32'(e_waddr));
      chk("regwrite", 32'(mem_wb_regwrite),   32'(e_rw));
      chk("mem_err",  32'(mem_err),           32'(e_err));
    end
  end

  logic [3:0] legal [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};

  function automatic logic [3:0] pick_pattern();
    int r;
    r = $urandom_range(0, 9);
    if (r < 7) return legal[r];
    if (r == 7) return 4'b0000;
    return 4'($urandom);
  endfunction

  initial begin
    reset_n = 1'b0; stall = 0; bubble = 0; ex_mem_instr = 0; ex_mem_pc = 0; alu_out = 0;
    store_data = 0; mem_write = 0; mem_read = 0; load_signed = 0; ex_mem_waddr = 0;
    ex_mem_regwrite = 0;
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_result",   mem_wb_result,             32'h0);
    chk("rst_instr",    mem_wb_instr,              32'h0);
    chk("rst_regwrite", 32'(mem_wb_regwrite),      32'h0);
    reset_n  = 1'b1;
    check_en = 1'b1;

    // SB 0xAB into lane 3 of word 0, then LB and LBU.
    drive(32'hA0000001, 32'h3, 32'h123456AB, 4'b1000, 4'b0000, 1'b0, 1'b0, 1'b0);
    drive(32'h80000002, 32'h3, 32'h0, 4'b0000, 4'b1000, 1'b1, 1'b0, 1'b0);
    chk("lit_lb",  mem_wb_result, 32'hFFFFFFAB);
    drive(32'h90000003, 32'h3, 32'h0, 4'b0000, 4'b1000, 1'b0, 1'b0, 1'b0);
    chk("lit_lbu", mem_wb_result, 32'h000000AB);

    // SW, SH upper half, then LW / LH / LHU.
    drive(32'hAC000004, 32'h8, 32'hDEADBEEF, 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0);
    drive(32'hA4000005, 32'hA, 32'h0000CAFE, 4'b1100, 4'b0000, 1'b0, 1'b0, 1'b0);
    drive(32'h8C000006, 32'h8, 32'h0, 4'b0000, 4'b1111, 1'b0, 1'b0, 1'b0);
    chk("lit_lw",  mem_wb_result, 32'hCAFEBEEF);
    drive(32'h84000007, 32'hA, 32'h0, 4'b0000, 4'b1100, 1'b1, 1'b0, 1'b0);
    chk("lit_lh",  mem_wb_result, 32'hFFFFCAFE);
    drive(32'h94000008, 32'h8, 32'h0, 4'b0000, 4'b0011, 1'b0, 1'b0, 1'b0);
    chk("lit_lhu", mem_wb_result, 32'h0000BEEF);

    // Stalled SW: no write, outputs held; then stall+bubble, then bubble alone.
    drive(32'hAC000009, 32'h0, 32'h11111111, 4'b1111, 4'b0000, 1'b0, 1'b1, 1'b0);
    drive(32'hAC000009, 32'h0, 32'h11111111, 4'b1111, 4'b0000, 1'b0, 1'b1, 1'b0);
    chk("lit_stall_hold", mem_wb_instr, 32'h94000008);
    drive(32'hAC00000A, 32'h0, 32'h22222222, 4'b1111, 4'b0000, 1'b0, 1'b1, 1'b1);
    chk("lit_stall_bubble", mem_wb_result, 32'h0000BEEF);
    drive(32'h8C00000B, 32'h0, 32'h0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1);
    chk("lit_bubble_instr", mem_wb_instr, 32'h0);
    chk("lit_bubble_rw",    32'(mem_wb_regwrite), 32'h0);
    drive(32'h8C00000C, 32'h0, 32'h0, 4'b0000, 4'b1111, 1'b0, 1'b0, 1'b0);
    chk("lit_word0_kept", mem_wb_result, 32'hAB000000);

    // Out-of-range store and illegal enable pattern.
    drive(32'hAC00000D, 32'(BYTES), 32'h55555555, 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0);
    chk("lit_err_range", 32'(mem_err), 32'h1);
    drive(32'hAC00000E, 32'h0, 32'h66666666, 4'b0101, 4'b0000, 1'b0, 1'b0, 1'b0);
    chk("lit_err_pattern", 32'(mem_err), 32'h1);
    drive(32'h8C00000F, 32'h0, 32'h0, 4'b0000, 4'b1111, 1'b0, 1'b0, 1'b0);
    chk("lit_err_nowrite", mem_wb_result, 32'hAB000000);
    chk("lit_err_clear",   32'(mem_err), 32'h0);

    // Asynchronous reset between clock edges.
    #2 reset_n = 1'b0;
    model_clear();
    #1;
    chk("lit_async_result", mem_wb_result, 32'h0);
    chk("lit_async_pc",     mem_wb_pc,     32'h0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    drive(32'h8C000010, 32'h8, 32'h0, 4'b0000, 4'b1111, 1'b0, 1'b0, 1'b0);
    chk("lit_after_reset_lw", mem_wb_result, 32'h0);

    // Randomized traffic over a small address window with occasional out-of-range.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] a;
      logic [3:0]  mw, mr;
      if ($urandom_range(0, 19) == 0) a = 32'(BYTES) + $urandom_range(0, 4000);
      else a = $urandom_range(0, 127);
      mw = 4'b0000; mr = 4'b0000;
      case ($urandom_range(0, 4))
        0, 1: mw = pick_pattern();
        2, 3: mr = pick_pattern();
        default: begin mw = pick_pattern(); mr = pick_pattern(); end
      endcase
      if (i == 1500) begin
        #3 reset_n = 1'b0;
        model_clear();
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
      end
      drive($urandom, a, $urandom, mw, mr, 1'($urandom),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
    end

    check_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
